// File: rtl/shift_seq_pkg.sv
// Shared constants and state encoding for the shift sequencer.
package shift_seq_pkg;

    localparam logic [1:0] MODE_LOGIC = 2'b00;
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;
    localparam logic [1:0] MODE_ONES  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_shift_4_bit.sv
// 4-bit one-position shifter: sel=0 shifts left, sel=1 shifts right.
// Caller supplies the bits entering at either end.
module shift_4_bit
    import shift_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic       sel,
    input  logic       shift_in_left,
    input  logic       shift_in_right,
    output logic [3:0] s,
    output logic       bb_left,
    output logic       bb_right
);

    // One-position shift with the bits that fall off each end exposed.
    always_comb begin
        s        = a;
        bb_left  = a[3];
        bb_right = a[0];
        if (sel == DIR_RIGHT) begin
            s = {shift_in_left, a[3:1]};
        end else begin
            s = {a[2:0], shift_in_right};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller stepping shift_4_bit once per clock.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_carry,
    output logic             busy
);

    state_t           state_q, state_n;
    logic [3:0]       data_q, data_n;
    logic [AMT_W-1:0] cnt_q, cnt_n;
    logic             dir_q, dir_n;
    logic [1:0]       mode_q, mode_n;
    logic             carry_q, carry_n;

    logic             fill;
    logic [3:0]       step_s;
    logic             step_bb_left;
    logic             step_bb_right;

    shift_4_bit u_step (
        .a              (data_q),
        .sel            (dir_q),
        .shift_in_left  (fill),
        .shift_in_right (fill),
        .s              (step_s),
        .bb_left        (step_bb_left),
        .bb_right       (step_bb_right)
    );

    // Fill bit for the current step; rotate recirculates the bit falling off.
    always_comb begin
        fill = 1'b0;
        unique case (mode_q)
            MODE_LOGIC: fill = 1'b0;
            MODE_ARITH: fill = (dir_q == DIR_RIGHT) ? data_q[3] : 1'b0;
            MODE_ROT:   fill = (dir_q == DIR_RIGHT) ? data_q[0] : data_q[3];
            MODE_ONES:  fill = 1'b1;
            default:    fill = 1'b0;
        endcase
    end

    // Next-state and datapath update for IDLE -> SHIFT* -> DONE sequencing.
    always_comb begin
        state_n = state_q;
        data_n  = data_q;
        cnt_n   = cnt_q;
        dir_n   = dir_q;
        mode_n  = mode_q;
        carry_n = carry_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_n  = in_data;
                    cnt_n   = in_amt;
                    dir_n   = in_dir;
                    mode_n  = in_mode;
                    carry_n = 1'b0;
                    state_n = (in_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_n  = step_s;
                carry_n = (dir_q == DIR_RIGHT) ? step_bb_right : step_bb_left;
                cnt_n   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_n;
            data_q  <= data_n;
            cnt_q   <= cnt_n;
            dir_q   <= dir_n;
            mode_q  <= mode_n;
            carry_q <= carry_n;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with an arithmetic reference model.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic             out_carry;
    logic             busy;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result {carry, data} computed arithmetically from the mode rules.
    function automatic logic [4:0] model_op(input logic [3:0] d, input int n,
                                            input logic dir, input logic [1:0] mode);
        int di, w, v, r, c, k;
        di = int'(d);
        r  = 0;
        c  = 0;
        if (mode == MODE_ROT) begin
            k = n % 4;
            if (dir == DIR_LEFT) r = ((di << k) | (di >> (4 - k))) & 15;
            else                 r = ((di >> k) | (di << (4 - k))) & 15;
            if (n != 0) c = (dir == DIR_LEFT) ? (r & 1) : ((r >> 3) & 1);
        end else if (dir == DIR_LEFT) begin
            w = (di << n) | ((mode == MODE_ONES) ? ((1 << n) - 1) : 0);
            r = w & 15;
            if (n != 0) c = (w >> 4) & 1;
        end else begin
            w = (di << 8);
            if (mode == MODE_ONES || (mode == MODE_ARITH && d[3])) w = w | int'(32'hFFFFF000);
            v = w >> n;
            r = (v >> 8) & 15;
            if (n != 0) c = (v >> 7) & 1;
        end
        return {c[0], r[3:0]};
    endfunction

    // Transaction-level expectation: busy from acceptance, valid after amt steps.
    logic       m_busy = 1'b0;
    logic       m_valid = 1'b0;
    int         m_wait = 0;
    logic [4:0] m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_wait  <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy  <= 1'b1;
                m_wait  <= int'(in_amt);
                m_valid <= (in_amt == '0);
                m_res   <= model_op(in_data, int'(in_amt), in_dir, in_mode);
            end
        end else if (!m_valid) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_valid <= 1'b1;
        end else if (out_ready) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_in_ready", 32'(in_ready), 32'(!m_busy));
            chk("mon_busy", 32'(busy), 32'(m_busy));
            chk("mon_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("mon_out_data", 32'(out_data), 32'(m_res[3:0]));
                chk("mon_out_carry", 32'(out_carry), 32'(m_res[4]));
            end
        end
    end

    task automatic send(input logic [3:0] d, input int a, input logic dr, input logic [1:0] m);
        @(negedge clk);
        chk("send_in_ready", 32'(in_ready), 32'd1);
        in_data  = d;
        in_amt   = AMT_W'(a);
        in_dir   = dr;
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic await_result(input string name, input int exp_lat,
                                input logic [3:0] exp_d, input logic exp_c);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_data"}, 32'(out_data), 32'(exp_d));
        chk({name, "_carry"}, 32'(out_carry), 32'(exp_c));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_idle_reset(input string name);
        chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({name, "_out_data"}, 32'(out_data), 32'd0);
        chk({name, "_out_carry"}, 32'(out_carry), 32'd0);
    endtask

    initial begin
        logic [3:0] held_d;
        logic       held_c;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_amt = '0; in_dir = 1'b0; in_mode = '0;

        // Literal pins on the model itself.
        chk("pin_lsl", 32'(model_op(4'b1011, 2, DIR_LEFT, MODE_LOGIC)), 32'b0_1100);
        chk("pin_asr", 32'(model_op(4'b1001, 2, DIR_RIGHT, MODE_ARITH)), 32'b0_1110);
        chk("pin_ror5", 32'(model_op(4'b0011, 5, DIR_RIGHT, MODE_ROT)), 32'b1_1001);
        chk("pin_ror4", 32'(model_op(4'b0011, 4, DIR_RIGHT, MODE_ROT)), 32'b0_0011);
        chk("pin_ones7", 32'(model_op(4'b1011, 7, DIR_LEFT, MODE_ONES)), 32'b1_1111);

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_reset("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset in the middle of a 7-step shift aborts it.
        send(4'b1011, 7, DIR_RIGHT, MODE_ONES);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_reset("mid_reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_valid_after_abort", 32'(out_valid), 32'd0);
        end

        // Directed vectors with hand-computed results.
        send(4'b1011, 2, DIR_LEFT, MODE_LOGIC);
        await_result("lsl2", 3, 4'b1100, 1'b0);
        drain();

        send(4'b1001, 2, DIR_RIGHT, MODE_ARITH);
        await_result("asr2", 3, 4'b1110, 1'b0);
        drain();

        send(4'b0000, 3, DIR_RIGHT, MODE_ONES);
        await_result("ones_r3", 4, 4'b1110, 1'b0);
        drain();

        send(4'b0011, 5, DIR_RIGHT, MODE_ROT);
        await_result("ror5", 6, 4'b1001, 1'b1);
        drain();

        send(4'b0011, 4, DIR_RIGHT, MODE_ROT);
        await_result("ror4", 5, 4'b0011, 1'b0);
        drain();

        send(4'b0110, 0, DIR_LEFT, MODE_LOGIC);
        await_result("amt0", 1, 4'b0110, 1'b0);
        drain();

        send(4'b1011, 7, DIR_LEFT, MODE_ONES);
        await_result("ones_l7", 8, 4'b1111, 1'b1);
        drain();

        send(4'b1000, 7, DIR_RIGHT, MODE_ARITH);
        await_result("asr7", 8, 4'b1111, 1'b1);
        drain();

        send(4'b1001, 1, DIR_LEFT, MODE_ROT);
        await_result("rol1", 2, 4'b0011, 1'b1);
        drain();

        // Backpressure: result held while a new request waits.
        send(4'b1011, 2, DIR_LEFT, MODE_LOGIC);
        await_result("bp", 3, 4'b1100, 1'b0);
        held_d = out_data;
        held_c = out_carry;
        in_data = 4'b0101; in_amt = AMT_W'(1); in_dir = DIR_LEFT; in_mode = MODE_LOGIC;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data_stable", 32'(out_data), 32'(held_d));
            chk("bp_carry_stable", 32'(out_carry), 32'(held_c));
        end
        out_ready = 1'b1;
        chk("bp_no_bypass", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_back_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accepted", 32'(busy), 32'd1);
        await_result("bp_next", 2, 4'b1010, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller that sequences the team's 4-bit one-position shifter (shift_4_bit) to perform shifts and rotates of 0..2^AMT_W-1 positions.
- Per accepted request, steps the shifter once per clock, choosing the fill bit by mode.
- Tracks the last bit shifted out as a carry flag.
- Returns the result through a valid/ready handshake.
- Sits between the ALU operation decoder and the ALU result mux.

Parameters:
AMT_W, 3, width of the shift-amount field; maximum amount is 2^AMT_W-1.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  request present.
in_ready  out  1  sequencer can accept; high only in IDLE.
in_data  in  4  operand.
in_amt  in  AMT_W  number of single-bit steps.
in_dir  in  1  0 = left, 1 = right; same encoding as the shifter's select input.
in_mode  in  2  fill mode: 00 logical, 01 arithmetic, 10 rotate, 11 fill-ones.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_data  out  4  shifted result.
out_carry  out  1  last bit shifted out; 0 if amount was 0.
busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (synchronous, active-high), with rst sampled high at a clk edge:
  - state returns to IDLE; all registers clear.
  - out_valid=0, out_data=0, out_carry=0, busy=0, in_ready=1.
  - Reset mid-SHIFT or mid-DONE aborts the operation; the result is discarded and no out_valid is produced.
  - rst has priority over all handshakes in the same cycle.
- Datapath registers: data_q[3:0], remaining count cnt_q[AMT_W-1:0], dir_q, mode_q, carry_q.
- Each SHIFT cycle feeds data_q into one shift_4_bit instance and registers its S output into data_q.
- Fill bit and carry, left (dir 0): bit entering at bit 0 drives the shifter's right-side shift-in; carry = bb_left (old bit 3).
- Fill bit and carry, right (dir 1): bit entering at bit 3 drives the left-side shift-in; carry = bb_right (old bit 0).
- Fill by mode:
  - logical: 0.
  - arithmetic: right fills data_q[3]; left behaves as logical.
  - rotate: the bit shifted out in the same step.
  - fill-ones: 1.
- States:
  - IDLE: in_ready=1. On in_valid, capture all inputs and set carry_q=0. Go to SHIFT if in_amt!=0, else DONE.
  - SHIFT: each cycle performs one step, updates carry_q and decrements cnt_q. When cnt_q==1 the step is the last one; go to DONE.
  - DONE: out_valid=1; out_data=data_q; out_carry=carry_q; outputs held stable. On out_ready, go to IDLE.
- Latency: N+1 cycles from the acceptance edge to the first cycle with out_valid high; amount 0 gives 1 cycle.
- Throughput: one request per N+2 cycles minimum.
- No bypass: in_ready stays 0 in DONE, even in the cycle out_ready is high.
- in_valid outside IDLE is ignored. Inputs are sampled only at the acceptance edge.
- Rotate by any multiple of 4 returns the operand unchanged; carry = bit last rotated out.
- Maximum amount 2^AMT_W-1 with no wrap of the count.
- out_data and out_carry are don't-care when out_valid=0; they hold their reset/previous value and are never X after reset.

Decomposition:
- Package shift_seq_pkg holds:
  - mode constants MODE_LOGIC=2'b00, MODE_ARITH=2'b01, MODE_ROT=2'b10, MODE_ONES=2'b11.
  - direction constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - state encoding IDLE/SHIFT/DONE (2 bits).
- One sub-module: the existing shift_4_bit, instantiated once as the per-step datapath.
- Fill-bit mux and FSM live in shift_sequencer.

Test Plan:
1. Reset: hold rst 2 cycles -> out_valid=0, busy=0, in_ready=1, out_data=0000, out_carry=0. Then check the same values with rst asserted mid-SHIFT of a 7-step request -> no out_valid follows.
2. Logical left: data 1011, amt 2, dir 0, mode 00 -> out_valid 3 cycles after accept, out_data 1100, out_carry 0.
3. Arithmetic right: data 1001, amt 2, dir 1, mode 01 -> out_data 1110, out_carry 0. Fill-ones right, data 0000, amt 3 -> 1110, carry 0.
4. Rotate: data 0011, amt 5, dir 1, mode 10 -> out_data 1001, out_carry 1, latency 6. Same operand, amt 4 -> 0011, carry 0.
5. Amount zero: data 0110, amt 0 -> out_valid 1 cycle after accept, out_data 0110, out_carry 0.
6. Backpressure: out_ready held low 3 cycles in DONE with in_valid high -> outputs stable, in_ready 0, new request not accepted. After out_ready pulse -> IDLE, next request accepted the following cycle.
